// File: rtl/operand_preproc_pipe.sv
// Purpose : operand preprocessor for the Booth-4/Wallace signed multiplier. It produces the
//           product sign, |A|, |B| and a zero-product flag, and presents them through a
//           registered valid/ready stage.
// Latency : 1 cycle from the accept edge to out_valid with results. 1 pair/cycle while out_ready=1.
// Backpressure: with PREPROC_SKID_EN defined, a two-entry skid buffer is used and in_ready is
//           registered. Otherwise there is a single stage and in_ready = out_ready | ~out_valid.
// Ports   : clk, rst (async, active-high); in_valid/in_ready, mode_signed, a_num, b_num on the
//           input side; out_valid/out_ready, a_mag, b_mag, sign, zero on the output side.
module operand_preproc_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] a_num,
    input  logic [WIDTH-1:0] b_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             sign,
    output logic             zero
);

    typedef struct packed {
        logic [WIDTH-1:0] a_mag;
        logic [WIDTH-1:0] b_mag;
        logic             sign;
        logic             zero;
    } res_t;

    // Combinational preprocessing of the pair currently on the inputs.
    logic a_neg, b_neg;
    res_t new_res;

    always_comb begin
        a_neg = mode_signed & a_num[WIDTH-1];
        b_neg = mode_signed & b_num[WIDTH-1];
        new_res = '0;
        // Negating the most-negative value wraps back to itself. Read as unsigned, that is the
        // correct magnitude.
        new_res.a_mag = a_neg ? ({WIDTH{1'b0}} - a_num) : a_num;
        new_res.b_mag = b_neg ? ({WIDTH{1'b0}} - b_num) : b_num;
        new_res.zero  = (a_num == '0) | (b_num == '0);
        new_res.sign  = (a_neg ^ b_neg) & ~new_res.zero;
    end

    res_t main_q, main_d;
    logic out_valid_q;
    logic accept;

`ifdef PREPROC_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL} state_t;

    state_t state_q, state_d;
    res_t   skid_q, skid_d;
    logic   in_ready_q;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = new_res;
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                if (accept && out_ready) begin
                    main_d = new_res;
                end else if (accept) begin
                    skid_d  = new_res;
                    state_d = S_FULL;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so draining only promotes the skid entry.
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = S_HALF;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // The handshake outputs are registered from the next state. This keeps every output a
    // flop and removes any combinational path from out_ready to in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != S_EMPTY);
            in_ready_q  <= (state_d != S_FULL);
        end
    end

    assign in_ready = in_ready_q;
`else
    logic out_valid_d;

    assign in_ready = out_ready | ~out_valid_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        main_d      = accept ? new_res : main_q;
        out_valid_d = accept | (out_valid_q & ~out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign a_mag     = main_q.a_mag;
    assign b_mag     = main_q.b_mag;
    assign sign      = main_q.sign;
    assign zero      = main_q.zero;

endmodule

// File: tb/tb_operand_preproc_pipe.sv
// Purpose : self-checking bench for operand_preproc_pipe. It drives a WIDTH=16 and a WIDTH=8
//           instance from shared handshakes and checks both against a queue-based reference
//           model on every negedge.
// Latency : expects results 1 cycle after the accept edge.
// Backpressure: random out_ready; expected in_ready follows the PREPROC_SKID_EN build option.
module tb_operand_preproc_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        mode_signed = 1'b0;
    logic [15:0] a_num = '0;
    logic [15:0] b_num = '0;

    logic        in_ready, out_valid, sign, zero;
    logic [15:0] a_mag, b_mag;
    logic        in_ready8, out_valid8, sign8, zero8;
    logic [7:0]  a_mag8, b_mag8;

    operand_preproc_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode_signed(mode_signed), .a_num(a_num), .b_num(b_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_mag(a_mag), .b_mag(b_mag), .sign(sign), .zero(zero)
    );

    operand_preproc_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .mode_signed(mode_signed), .a_num(a_num[7:0]), .b_num(b_num[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready),
        .a_mag(a_mag8), .b_mag(b_mag8), .sign(sign8), .zero(zero8)
    );

    always #5 clk = ~clk;

`ifdef PREPROC_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        longint a, b;
        bit     s, z;
        longint a8, b8;
        bit     s8, z8;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: interpret, take the absolute value, reduce modulo 2^w.
    function automatic void mdl(input int w, input bit m, input longint a, input longint b,
                                output longint am, output longint bm, output bit s, output bit z);
        longint full, half, ia, ib;
        full = longint'(1) << w;
        half = full >> 1;
        ia = (m && a >= half) ? a - full : a;
        ib = (m && b >= half) ? b - full : b;
        am = (ia < 0 ? -ia : ia) % full;
        bm = (ib < 0 ? -ib : ib) % full;
        z  = (a == 0) || (b == 0);
        s  = ((ia < 0) != (ib < 0)) && !z;
    endfunction

    function automatic exp_t make_exp(input bit m, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        mdl(16, m, longint'(a), longint'(b), e.a, e.b, e.s, e.z);
        mdl(8, m, longint'(a[7:0]), longint'(b[7:0]), e.a8, e.b8, e.s8, e.z8);
        return e;
    endfunction

    // Compare process: everything is stable at the negedge for the coming rising edge.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_a, prev_b;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            chk("out_valid8", {31'b0, out_valid8}, {31'b0, q.size() != 0});
            if (DEPTH == 2) begin
                chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            end else begin
                chk("in_ready", {31'b0, in_ready}, {31'b0, out_ready || q.size() == 0});
            end
            chk("in_ready8", {31'b0, in_ready8}, {31'b0, in_ready});
            if (out_valid && q.size() != 0) begin
                chk("a_mag", {16'b0, a_mag}, 32'(q[0].a));
                chk("b_mag", {16'b0, b_mag}, 32'(q[0].b));
                chk("sign", {31'b0, sign}, {31'b0, q[0].s});
                chk("zero", {31'b0, zero}, {31'b0, q[0].z});
                chk("a_mag8", {24'b0, a_mag8}, 32'(q[0].a8));
                chk("b_mag8", {24'b0, b_mag8}, 32'(q[0].b8));
                chk("sign8", {31'b0, sign8}, {31'b0, q[0].s8});
                chk("zero8", {31'b0, zero8}, {31'b0, q[0].z8});
            end
            if (prev_stall) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_a", {16'b0, a_mag}, {16'b0, prev_a});
                chk("hold_b", {16'b0, b_mag}, {16'b0, prev_b});
            end
            prev_stall = out_valid && !out_ready;
            prev_a = a_mag;
            prev_b = b_mag;
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) q.push_back(make_exp(mode_signed, a_num, b_num));
        end
    end

    // Single-pair directed check with hand-computed results. Called at posedge+1 with out_ready=1.
    task automatic one(input bit m, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ea, input logic [15:0] eb, input bit es, input bit ez);
        mode_signed = m; a_num = a; b_num = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lit_valid", {31'b0, out_valid}, 32'd1);
        chk("lit_a_mag", {16'b0, a_mag}, {16'b0, ea});
        chk("lit_b_mag", {16'b0, b_mag}, {16'b0, eb});
        chk("lit_sign", {31'b0, sign}, {31'b0, es});
        chk("lit_zero", {31'b0, zero}, {31'b0, ez});
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h0080;
            3: return {8'($urandom), 8'h00};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] bp_a [4];
    int idx, base;
    bit acc;

    initial begin
        bp_a[0] = 16'hFFF0; bp_a[1] = 16'h0011; bp_a[2] = 16'h8000; bp_a[3] = 16'h7FFF;

        // Asynchronous reset at time 1, before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_a_mag", {16'b0, a_mag}, 32'd0);
        chk("rst_b_mag", {16'b0, b_mag}, 32'd0);
        chk("rst_sign_zero", {30'b0, sign, zero}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed pairs with literal expectations.
        out_ready = 1'b1;
        one(1'b1, 16'hFFFD, 16'h0005, 16'h0003, 16'h0005, 1'b1, 1'b0);
        chk("lit8_a_mag", {24'b0, a_mag8}, 32'd3);
        one(1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b0);
        one(1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0001, 1'b1, 1'b0);
        one(1'b1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b1);
        one(1'b0, 16'hFFFF, 16'h0002, 16'hFFFF, 16'h0002, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Back-pressure: stream four pairs into a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1; mode_signed = 1'b1; idx = 0;
        a_num = bp_a[0]; b_num = 16'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 4) begin a_num = bp_a[idx]; b_num = 16'(idx + 2); end
        end
        chk("bp_accepted", idx, DEPTH);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        base = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_no_gap", {31'b0, out_valid}, 32'd1);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 4) begin a_num = bp_a[idx]; b_num = 16'(idx + 2); end
            else in_valid = 1'b0;
        end
        chk("bp_emerged", n_out - base, 4);
        @(posedge clk); #1;

        // Fill the pipe, then assert reset mid-cycle.
        out_ready = 1'b0; in_valid = 1'b1; a_num = 16'h1111; b_num = 16'h2222;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            a_num = a_num + 16'h0101;
        end
        in_valid = 1'b0;
        #2;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_a_mag", {16'b0, a_mag}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        mode_signed = 1'b0; a_num = 16'h1234; b_num = 16'h0042;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_a_mag", {16'b0, a_mag}, 32'h1234);
        chk("post_rst_b_mag", {16'b0, b_mag}, 32'h0042);

        // Random traffic with random back-pressure. The source holds a pair until it is taken.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (!(in_valid && !acc)) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                mode_signed = 1'($urandom_range(0, 1));
                a_num       = rnd_op();
                b_num       = rnd_op();
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end

        // Drain.
        @(posedge clk); #1;
        in_valid = (in_valid && !in_ready);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
